// File: rtl/multichannel_delay_line_if.sv
// Bundles the sample, control and status signals of multichannel_delay_line.
// master = sample source and status reader; slave = the delay line itself.
interface multichannel_delay_line_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 2,
   parameter int DELAY_W  = 10,
   parameter int CH_W     = 1
);
   logic                         enable_in;
   logic                         invert_in;
   logic                         sample_valid_in;
   logic [WIDTH-1:0]             sample_in;
   logic [CH_W-1:0]              sample_ch_in;
   logic [CHANNELS*DELAY_W-1:0]  delay_in;
   logic                         delayed_valid_out;
   logic [WIDTH-1:0]             delayed_out;
   logic [CH_W-1:0]              delayed_ch_out;
   logic [CHANNELS-1:0]          primed_out;
   logic                         bad_ch_out;

   modport master (
      output enable_in, invert_in, sample_valid_in, sample_in, sample_ch_in, delay_in,
      input  delayed_valid_out, delayed_out, delayed_ch_out, primed_out, bad_ch_out
   );

   modport slave (
      input  enable_in, invert_in, sample_valid_in, sample_in, sample_ch_in, delay_in,
      output delayed_valid_out, delayed_out, delayed_ch_out, primed_out, bad_ch_out
   );
endinterface

// File: rtl/multichannel_delay_line.sv
// Time-multiplexed per-channel sample delay line sharing one read-first RAM, 2-cycle latency.
// Define MULTICHANNEL_DELAY_SAT_NEG_EN for saturating negation of the most negative sample.
module multichannel_delay_line #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 1024,
   parameter int CHANNELS = 2,
   parameter int DELAY_W  = $clog2(DEPTH),
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input logic                    clk_in,
   input logic                    rst_n_in,
   multichannel_delay_line_if.slave bus
);

   localparam int ADDR_W = $clog2(CHANNELS * DEPTH);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = $clog2(DEPTH + 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

   logic [PTR_W-1:0]  wr_ptr    [CHANNELS];
   logic [FILL_W-1:0] fill      [CHANNELS];
   logic [FILL_W-1:0] fill_cur  [CHANNELS];
   logic [PTR_W-1:0]  delay_eff [CHANNELS];

   logic              enable_q;
   logic              enable_rise;
   logic              ch_ok;
   logic              accept;
   logic [PTR_W-1:0]  sel_ptr;
   logic [FILL_W-1:0] sel_fill;
   logic [PTR_W-1:0]  sel_delay;
   logic [PTR_W-1:0]  rd_ofs;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic              mask;
   logic              bypass;
   logic              fwd_hit;

   logic [WIDTH-1:0]  mem [0:CHANNELS*DEPTH-1];
   logic [WIDTH-1:0]  rd_data;

   logic              last_wr_valid;
   logic [ADDR_W-1:0] last_wr_addr;
   logic [WIDTH-1:0]  last_wr_data;

   logic              s1_valid;
   logic [CH_W-1:0]   s1_ch;
   logic              s1_bypass;
   logic              s1_mask;
   logic              s1_invert;
   logic              s1_fwd;
   logic [WIDTH-1:0]  s1_sample;
   logic [WIDTH-1:0]  s1_fwd_data;

   logic [WIDTH-1:0]  s2_data;
   logic [WIDTH-1:0]  s2_neg;
   logic [WIDTH-1:0]  s2_result;

   assign enable_rise = bus.enable_in && !enable_q;

   // Out-of-range delays only exist when DEPTH is not a power of two; they pin to the oldest sample.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (32'(bus.delay_in[c*DELAY_W +: DELAY_W]) >= DEPTH) begin
            delay_eff[c] = PTR_W'(DEPTH - 1);
         end else begin
            delay_eff[c] = PTR_W'(bus.delay_in[c*DELAY_W +: DELAY_W]);
         end
         fill_cur[c] = enable_rise ? '0 : fill[c];
      end
   end

   always_comb begin
      bus.primed_out = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         bus.primed_out[c] = 32'(fill_cur[c]) >= 32'(delay_eff[c]);
      end
   end

   always_comb begin
      ch_ok     = 32'(bus.sample_ch_in) < CHANNELS;
      accept    = bus.sample_valid_in && bus.enable_in && ch_ok;
      sel_ptr   = '0;
      sel_fill  = '0;
      sel_delay = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (bus.sample_ch_in == CH_W'(c)) begin
            sel_ptr   = wr_ptr[c];
            sel_fill  = fill_cur[c];
            sel_delay = delay_eff[c];
         end
      end
      if (sel_ptr >= sel_delay) begin
         rd_ofs = sel_ptr - sel_delay;
      end else begin
         rd_ofs = PTR_W'(32'(sel_ptr) + DEPTH - 32'(sel_delay));
      end
      base_addr = ADDR_W'(32'(bus.sample_ch_in) * DEPTH);
      wr_addr   = base_addr + ADDR_W'(sel_ptr);
      rd_addr   = base_addr + ADDR_W'(rd_ofs);
      mask      = 32'(sel_fill) < 32'(sel_delay);
      bypass    = (sel_delay == '0);
      fwd_hit   = last_wr_valid && (last_wr_addr == rd_addr);
   end

   // Per-channel write pointers and fill levels; a fresh enable forgets all history.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr[c] <= '0;
            fill[c]   <= '0;
         end
         enable_q       <= 1'b0;
         bus.bad_ch_out <= 1'b0;
      end else begin
         enable_q <= bus.enable_in;
         for (int c = 0; c < CHANNELS; c++) begin
            fill[c] <= fill_cur[c];
            if (accept && (bus.sample_ch_in == CH_W'(c))) begin
               wr_ptr[c] <= (32'(wr_ptr[c]) == DEPTH - 1) ? '0 : wr_ptr[c] + PTR_W'(1);
               if (32'(fill_cur[c]) < DEPTH) begin
                  fill[c] <= fill_cur[c] + FILL_W'(1);
               end
            end
         end
         if (bus.sample_valid_in && bus.enable_in && !ch_ok) begin
            bus.bad_ch_out <= 1'b1;
         end
      end
   end

   // Shared read-first RAM; contents are deliberately never reset.
   always_ff @(posedge clk_in) begin
      if (accept) begin
         mem[wr_addr] <= bus.sample_in;
         rd_data      <= mem[rd_addr];
      end
   end

   // Forwarding keeps d=1 back-to-back reads correct even if the RAM write lands a cycle late.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         last_wr_valid <= 1'b0;
         last_wr_addr  <= '0;
         last_wr_data  <= '0;
         s1_valid      <= 1'b0;
         s1_ch         <= '0;
         s1_bypass     <= 1'b0;
         s1_mask       <= 1'b0;
         s1_invert     <= 1'b0;
         s1_fwd        <= 1'b0;
         s1_sample     <= '0;
         s1_fwd_data   <= '0;
      end else begin
         last_wr_valid <= accept;
         s1_valid      <= accept;
         if (accept) begin
            last_wr_addr <= wr_addr;
            last_wr_data <= bus.sample_in;
            s1_ch        <= bus.sample_ch_in;
            s1_bypass    <= bypass;
            s1_mask      <= mask;
            s1_invert    <= bus.invert_in;
            s1_fwd       <= fwd_hit;
            s1_sample    <= bus.sample_in;
            s1_fwd_data  <= last_wr_data;
         end
      end
   end

   always_comb begin
      if (s1_mask) begin
         s2_data = '0;
      end else if (s1_bypass) begin
         s2_data = s1_sample;
      end else if (s1_fwd) begin
         s2_data = s1_fwd_data;
      end else begin
         s2_data = rd_data;
      end
`ifdef MULTICHANNEL_DELAY_SAT_NEG_EN
      s2_neg = (s2_data == MIN_VAL) ? MAX_VAL : (~s2_data + WIDTH'(1));
`else
      s2_neg = ~s2_data + WIDTH'(1);
`endif
      s2_result = s1_invert ? s2_neg : s2_data;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         bus.delayed_valid_out <= 1'b0;
         bus.delayed_out       <= '0;
         bus.delayed_ch_out    <= '0;
      end else begin
         bus.delayed_valid_out <= s1_valid;
         if (s1_valid) begin
            bus.delayed_out    <= s2_result;
            bus.delayed_ch_out <= s1_ch;
         end
      end
   end

endmodule

// File: tb/tb_multichannel_delay_line.sv
// Scoreboard bench for multichannel_delay_line: 3 channels (channel 3 is invalid), depth 8.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_multichannel_delay_line;

   localparam int WIDTH    = 16;
   localparam int DEPTH    = 8;
   localparam int CHANNELS = 3;
   localparam int DELAY_W  = 3;
   localparam int CH_W     = 2;

`ifdef MULTICHANNEL_DELAY_SAT_NEG_EN
   localparam logic [WIDTH-1:0] NEG_MIN = 16'h7FFF;
`else
   localparam logic [WIDTH-1:0] NEG_MIN = 16'h8000;
`endif

   typedef struct {
      logic [CH_W-1:0]  ch;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   multichannel_delay_line_if #(
      .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DELAY_W(DELAY_W), .CH_W(CH_W)
   ) bus_if ();

   multichannel_delay_line #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .DELAY_W(DELAY_W), .CH_W(CH_W)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus_if)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] sample,
                                input logic inv, input logic push, input logic [WIDTH-1:0] expd);
      exp_t e;
      @(posedge clk);
      #1;
      bus_if.sample_valid_in = 1'b1;
      bus_if.sample_ch_in    = ch;
      bus_if.sample_in       = sample;
      bus_if.invert_in       = inv;
      if (push) begin
         e.ch   = ch;
         e.data = expd;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus_if.sample_valid_in = 1'b0;
      end
   endtask

   task automatic setDelay(input int ch, input logic [DELAY_W-1:0] d);
      bus_if.delay_in[ch*DELAY_W +: DELAY_W] = d;
   endtask

   // Drop enable for one cycle while offering a sample that must be ignored, then re-enable.
   task automatic toggleEnable();
      @(posedge clk);
      #1;
      bus_if.enable_in       = 1'b0;
      bus_if.sample_valid_in = 1'b1;
      bus_if.sample_ch_in    = 2'd0;
      bus_if.sample_in       = 16'd99;
      @(posedge clk);
      #1;
      bus_if.sample_valid_in = 1'b0;
      bus_if.enable_in       = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus_if.delayed_valid_out) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_output", {16'd0, bus_if.delayed_out}, 32'hDEAD_BEEF);
         end else begin
            e = exp_q.pop_front();
            checkOutput("delayed_ch", 32'(bus_if.delayed_ch_out), 32'(e.ch));
            checkOutput("delayed_out", 32'(bus_if.delayed_out), 32'(e.data));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int wait_cycles;
      bus_if.enable_in       = 1'b0;
      bus_if.invert_in       = 1'b0;
      bus_if.sample_valid_in = 1'b0;
      bus_if.sample_in       = '0;
      bus_if.sample_ch_in    = '0;
      bus_if.delay_in        = '0;
      setDelay(0, 3'd3);
      setDelay(1, 3'd0);
      setDelay(2, 3'd5);

      #12;
      checkOutput("reset_valid", 32'(bus_if.delayed_valid_out), 32'd0);
      checkOutput("reset_data", 32'(bus_if.delayed_out), 32'd0);
      checkOutput("reset_ch", 32'(bus_if.delayed_ch_out), 32'd0);
      checkOutput("reset_bad_ch", 32'(bus_if.bad_ch_out), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus_if.enable_in = 1'b1;

      $display("[TB] interleaved ramp, d0=3 d1=0");
      applyStimulus(0, 16'd1, 0, 1, 16'd0);
      applyStimulus(1, 16'd100, 0, 1, 16'd100);
      applyStimulus(0, 16'd2, 0, 1, 16'd0);
      applyStimulus(1, 16'd101, 0, 1, 16'd101);
      idle(1);
      checkOutput("primed0_after_2", 32'(bus_if.primed_out[0]), 32'd0);
      checkOutput("primed1_d0", 32'(bus_if.primed_out[1]), 32'd1);
      applyStimulus(0, 16'd3, 0, 1, 16'd0);
      idle(1);
      checkOutput("primed0_after_3", 32'(bus_if.primed_out[0]), 32'd1);
      applyStimulus(1, 16'd102, 0, 1, 16'd102);
      applyStimulus(0, 16'd4, 0, 1, 16'd1);
      applyStimulus(1, 16'd103, 0, 1, 16'd103);
      applyStimulus(0, 16'd5, 0, 1, 16'd2);
      applyStimulus(1, 16'd104, 0, 1, 16'd104);
      applyStimulus(0, 16'd6, 0, 1, 16'd3);
      idle(4);

      $display("[TB] enable toggle then d=1 forwarding");
      setDelay(0, 3'd1);
      toggleEnable();
      #1;
      checkOutput("primed0_after_toggle", 32'(bus_if.primed_out[0]), 32'd0);
      applyStimulus(0, 16'd5, 0, 1, 16'd0);
      applyStimulus(0, 16'd6, 0, 1, 16'd5);
      applyStimulus(0, 16'd7, 0, 1, 16'd6);
      idle(4);

      $display("[TB] pointer wrap, d=7");
      setDelay(0, 3'd7);
      toggleEnable();
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(0, 16'(k), 0, 1, (k > 7) ? 16'(k - 7) : 16'd0);
      end
      idle(4);

      $display("[TB] invalid channel");
      checkOutput("bad_ch_before", 32'(bus_if.bad_ch_out), 32'd0);
      applyStimulus(3, 16'h0055, 0, 0, 16'd0);
      applyStimulus(2, 16'h0066, 0, 1, 16'd0);
      idle(3);
      checkOutput("bad_ch_after", 32'(bus_if.bad_ch_out), 32'd1);

      $display("[TB] inversion");
      applyStimulus(1, 16'h0001, 1, 1, 16'hFFFF);
      applyStimulus(1, 16'h8000, 1, 1, NEG_MIN);
      applyStimulus(1, 16'h1234, 1, 1, 16'hEDCC);
      idle(4);

      $display("[TB] async reset with sample in flight");
      applyStimulus(1, 16'h0077, 0, 0, 16'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus_if.sample_valid_in = 1'b0;
      #1;
      checkOutput("midreset_valid", 32'(bus_if.delayed_valid_out), 32'd0);
      checkOutput("midreset_data", 32'(bus_if.delayed_out), 32'd0);
      checkOutput("midreset_ch", 32'(bus_if.delayed_ch_out), 32'd0);
      checkOutput("midreset_bad_ch", 32'(bus_if.bad_ch_out), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      setDelay(0, 3'd2);
      applyStimulus(0, 16'h0042, 0, 1, 16'd0);
      applyStimulus(0, 16'h0043, 0, 1, 16'd0);
      applyStimulus(0, 16'h0044, 0, 1, 16'h0042);
      idle(2);

      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      idle(2);
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
